ram_port_arbiter: RTL

Shares the two ports of the 1024×18 dual-port RAM among `NUM_REQ` requesters with round-robin priority, granting up to two requests per cycle, one per port. After reset, or on command, it zeroes the whole RAM by sweeping all addresses, using both ports in parallel. It sits directly in front of `dual_port_ram`, which it owns exclusively. The RAM's `rst` input is tied low; this block performs all clearing.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_port_arbiter_if.sv | 41 ++++
 rtl/ram_arb_rr_pick.sv | 41 ++++
 rtl/ram_port_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared defaults and types for the dual-port RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_AW      = 10;
  localparam int DEF_DW      = 18;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Last clear-counter value: each clear cycle covers two addresses.
  function automatic int clear_last_for(input int aw);
    return (1 << (aw - 1)) - 1;
  endfunction

  localparam int CLEAR_LAST = clear_last_for(DEF_AW);

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester bus plus RAM port bundle between the arbiter and its environment.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) ();

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [NUM_REQ*DW-1:0] rdata;
  logic                  clear_start;
  logic                  busy;

  logic [AW-1:0]         ram_addrA;
  logic [AW-1:0]         ram_addrB;
  logic [DW-1:0]         ram_dataA;
  logic [DW-1:0]         ram_dataB;
  logic                  ram_weA;
  logic                  ram_weB;
  logic [DW-1:0]         ram_qA;
  logic [DW-1:0]         ram_qB;

  modport slave (
    input  req, req_we, req_addr, req_wdata, clear_start, ram_qA, ram_qB,
    output gnt, rvalid, rdata, busy,
    output ram_addrA, ram_addrB, ram_dataA, ram_dataB, ram_weA, ram_weB
  );

  modport master (
    output req, req_we, req_addr, req_wdata, clear_start, ram_qA, ram_qB,
    input  gnt, rvalid, rdata, busy,
    input  ram_addrA, ram_addrB, ram_dataA, ram_dataB, ram_weA, ram_weB
  );

endinterface

// File: rtl/ram_arb_rr_pick.sv
// Combinational round-robin picker: first and second asserted requesters
// scanning circularly from i_ptr.
module ram_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [PW-1:0]      o_idx_a,
  output logic [PW-1:0]      o_idx_b,
  output logic               o_vld_a,
  output logic               o_vld_b
);

  int            w_j;
  logic [PW-1:0] w_sel;

  always_comb begin
    o_idx_a = '0;
    o_idx_b = '0;
    o_vld_a = 1'b0;
    o_vld_b = 1'b0;
    w_j     = 0;
    w_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      w_sel = PW'(w_j);
      if (i_req[w_sel]) begin
        if (!o_vld_a) begin
          o_vld_a = 1'b1;
          o_idx_a = w_sel;
        end else if (!o_vld_b) begin
          o_vld_b = 1'b1;
          o_idx_b = w_sel;
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a dual-port RAM, with a
// full-RAM zero sweep after reset or on clear_start.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) (
  input  logic               clk,
  input  logic               rst,
  ram_port_arbiter_if.slave  bus
);

  localparam int            PW       = $clog2(NUM_REQ);
  localparam int            CW       = AW - 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(clear_last_for(AW));

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_clr_cnt;
  logic [PW-1:0]         r_ptr;

  logic [PW-1:0]         w_idx_a, w_idx_b;
  logic                  w_vld_a, w_vld_b;
  logic [AW-1:0]         w_addr_a, w_addr_b;
  logic                  w_we_a, w_we_b;
  logic [DW-1:0]         w_wd_a, w_wd_b;
  logic                  w_run;
  logic                  w_gnt_a, w_gnt_b;

  logic [NUM_REQ-1:0]    r_vld_p1;
  logic [NUM_REQ*DW-1:0] r_rdata_p1;

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  ram_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_idx_a (w_idx_a),
    .o_idx_b (w_idx_b),
    .o_vld_a (w_vld_a),
    .o_vld_b (w_vld_b)
  );

  assign w_addr_a = bus.req_addr[int'(w_idx_a)*AW +: AW];
  assign w_addr_b = bus.req_addr[int'(w_idx_b)*AW +: AW];
  assign w_wd_a   = bus.req_wdata[int'(w_idx_a)*DW +: DW];
  assign w_wd_b   = bus.req_wdata[int'(w_idx_b)*DW +: DW];
  assign w_we_a   = bus.req_we[w_idx_a];
  assign w_we_b   = bus.req_we[w_idx_b];
  assign w_run    = (r_state == S_RUN) && !rst;

  // Same-address pairs involving a write would race inside the RAM, so port B yields.
  always_comb begin
    w_gnt_a = w_run && w_vld_a;
    w_gnt_b = w_run && w_vld_b && !((w_addr_a == w_addr_b) && (w_we_a || w_we_b));
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_cnt == CLR_LAST) w_state_nxt = S_RUN;
      S_RUN:   if (bus.clear_start)       w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    bus.busy      = rst || (r_state == S_CLEAR);
    bus.gnt       = '0;
    bus.ram_addrA = '0;
    bus.ram_addrB = '0;
    bus.ram_dataA = '0;
    bus.ram_dataB = '0;
    bus.ram_weA   = 1'b0;
    bus.ram_weB   = 1'b0;
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        bus.ram_addrA = {r_clr_cnt, 1'b0};
        bus.ram_addrB = {r_clr_cnt, 1'b1};
        bus.ram_weA   = 1'b1;
        bus.ram_weB   = 1'b1;
      end else begin
        if (w_gnt_a) begin
          bus.gnt[w_idx_a] = 1'b1;
          bus.ram_addrA    = w_addr_a;
          bus.ram_weA      = w_we_a;
          bus.ram_dataA    = w_wd_a;
        end
        if (w_gnt_b) begin
          bus.gnt[w_idx_b] = 1'b1;
          bus.ram_addrB    = w_addr_b;
          bus.ram_weB      = w_we_b;
          bus.ram_dataB    = w_wd_b;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt <= '0;
      r_ptr     <= '0;
    end else begin
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      else                    r_clr_cnt <= '0;
      if (w_gnt_b)      r_ptr <= ptr_after(w_idx_b);
      else if (w_gnt_a) r_ptr <= ptr_after(w_idx_a);
    end
  end

  // Stage p1: capture asynchronous RAM read data at the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= '0;
      r_rdata_p1 <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_vld_p1[i] <= 1'b0;
        if (w_gnt_a && !w_we_a && (int'(w_idx_a) == i)) begin
          r_vld_p1[i]            <= 1'b1;
          r_rdata_p1[i*DW +: DW] <= bus.ram_qA;
        end else if (w_gnt_b && !w_we_b && (int'(w_idx_b) == i)) begin
          r_vld_p1[i]            <= 1'b1;
          r_rdata_p1[i*DW +: DW] <= bus.ram_qB;
        end
      end
    end
  end

  assign bus.rvalid = rst ? '0 : r_vld_p1;
  assign bus.rdata  = rst ? '0 : r_rdata_p1;

endmodule
